// File: rtl/add6_result_accum.sv
// rtl/add6_result_accum.sv - frame accumulator for 7-bit adder sums with saturating total and held result
//
// Sums arrive over in_valid/in_ready and are added into a saturating ACC_W-bit
// accumulator. After N accepted sums the block moves to HOLD. It then presents the total,
// the count and the sticky saturation flag until the consumer takes them.
// The frame length is latched on the first sample of each frame, so later
// n_samples changes do not affect that frame.

module add6_result_accum #(
  parameter int SUM_W   = 7,
  parameter int ACC_W   = 12,
  parameter int COUNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [COUNT_W-1:0] n_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUM_W-1:0]   in_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_sat
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_n_lat;
  logic               r_sat;
  logic               r_valid;

  logic               w_accept;
  logic [ACC_W:0]     w_sum_ext;
  logic               w_ovf;
  logic [COUNT_W-1:0] w_n_new;
  logic [COUNT_W-1:0] w_n_eff;
  logic [COUNT_W-1:0] w_count_inc;

  // in_ready is the only output that also looks at clear: a sample offered
  // during a clear cycle must be refused.
  assign in_ready  = (r_state == ST_ACCUM) && !clear;
  assign w_accept  = in_valid && in_ready;

  // One extra bit catches overflow before clamping.
  assign w_sum_ext = {1'b0, r_acc} + (ACC_W + 1)'(in_sum);
  assign w_ovf     = w_sum_ext[ACC_W];

  // A frame length of zero behaves as a single-sample frame.
  assign w_n_new     = (n_samples == '0) ? COUNT_W'(1) : n_samples;
  assign w_n_eff     = (r_count == '0) ? w_n_new : r_n_lat;
  assign w_count_inc = r_count + COUNT_W'(1);

  assign out_valid = r_valid;
  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign out_sat   = r_sat;

  // Frame FSM: accumulate in ACCUM, hold the result in HOLD until it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACCUM;
      r_acc   <= '0;
      r_count <= '0;
      r_n_lat <= '0;
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
    end else if (clear) begin
      r_state <= ST_ACCUM;
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_ovf ? ACC_MAX : w_sum_ext[ACC_W-1:0];
            r_count <= w_count_inc;
            if (w_ovf) begin
              r_sat <= 1'b1;
            end
            if (r_count == '0) begin
              r_n_lat <= w_n_new;
            end
            if (w_count_inc == w_n_eff) begin
              r_state <= ST_HOLD;
              r_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // The bubble cycle between frames comes from in_ready being low here.
          if (out_ready) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add6_result_accum.sv
// tb/tb_add6_result_accum.sv - randomized bench for add6_result_accum against a frame-level model

module tb_add6_result_accum;

  localparam int SUM_W   = 7;
  localparam int ACC_W   = 12;
  localparam int COUNT_W = 6;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic               clk;
  logic               rst;
  logic               clear;
  logic [COUNT_W-1:0] n_samples;
  logic               in_valid;
  logic               in_ready;
  logic [SUM_W-1:0]   in_sum;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_acc;
  logic [COUNT_W-1:0] out_count;
  logic               out_sat;

  int checks;
  int errors;

  // Frame-level model: the running total is kept unclamped. The visible
  // accumulator is min(total, max), and it has saturated once total > max.
  bit m_hold;
  int m_total;
  int m_count;
  int m_n;

  add6_result_accum #(
    .SUM_W  (SUM_W),
    .ACC_W  (ACC_W),
    .COUNT_W(COUNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .n_samples(n_samples),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_count(out_count),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic int exp_acc();
    return (m_total > ACC_MAX) ? ACC_MAX : m_total;
  endfunction

  // Compare every output against the model, then advance the model at the edge.
  task automatic tick();
    @(negedge clk);
    chk("out_valid", int'(out_valid), int'(m_hold));
    chk("out_acc", int'(out_acc), exp_acc());
    chk("out_count", int'(out_count), m_count);
    chk("out_sat", int'(out_sat), int'(m_total > ACC_MAX));
    chk("in_ready", int'(in_ready), int'(!m_hold && !clear));
    @(posedge clk);
    if (rst || clear) begin
      m_hold  = 1'b0;
      m_total = 0;
      m_count = 0;
    end else if (!m_hold) begin
      if (in_valid) begin
        if (m_count == 0) m_n = (n_samples == 0) ? 1 : int'(n_samples);
        m_total += int'(in_sum);
        m_count++;
        if (m_count == m_n) m_hold = 1'b1;
      end
    end else if (out_ready) begin
      m_hold  = 1'b0;
      m_total = 0;
      m_count = 0;
    end
    #1;
  endtask

  task automatic send(input int sum);
    in_valid = 1'b1;
    in_sum   = SUM_W'(sum);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_hold    = 1'b0;
    m_total   = 0;
    m_count   = 0;
    m_n       = 0;
    rst       = 1'b1;
    clear     = 1'b0;
    n_samples = '0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;

    // Reset for two cycles.
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_acc", int'(out_acc), 0);
    chk("rst_count", int'(out_count), 0);
    chk("rst_sat", int'(out_sat), 0);
    chk("rst_ready", int'(in_ready), 1);

    // Three-sample frame.
    n_samples = 6'd3;
    send(10);
    send(20);
    send(127);
    chk("f3_valid", int'(out_valid), 1);
    chk("f3_acc", int'(out_acc), 157);
    chk("f3_count", int'(out_count), 3);
    chk("f3_sat", int'(out_sat), 0);
    chk("f3_ready", int'(in_ready), 0);

    // Backpressure, including a sample offered while holding.
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_sum   = 7'd50;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_acc", int'(out_acc), 157);
    chk("bp_valid", int'(out_valid), 1);
    consume();
    chk("cons_valid", int'(out_valid), 0);
    chk("cons_acc", int'(out_acc), 0);
    chk("cons_ready", int'(in_ready), 1);

    // Saturating frame of 40 maximum sums.
    n_samples = 6'd40;
    for (int i = 1; i <= 40; i++) begin
      send(127);
      if (i == 32) chk("sat32_acc", int'(out_acc), 4064);
      if (i == 33) begin
        chk("sat33_acc", int'(out_acc), 4095);
        chk("sat33_sat", int'(out_sat), 1);
      end
    end
    chk("sat_acc", int'(out_acc), 4095);
    chk("sat_sat", int'(out_sat), 1);
    chk("sat_count", int'(out_count), 40);
    chk("sat_valid", int'(out_valid), 1);
    consume();

    // Clear in mid-frame drops the sample offered in that cycle.
    n_samples = 6'd4;
    send(5);
    send(5);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_sum   = 7'd9;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_acc", int'(out_acc), 0);
    chk("clr_count", int'(out_count), 0);
    for (int i = 0; i < 4; i++) send(1);
    chk("clr_frame_acc", int'(out_acc), 4);
    chk("clr_frame_valid", int'(out_valid), 1);
    consume();

    // The frame length is latched on the first sample.
    n_samples = 6'd2;
    send(1);
    n_samples = 6'd5;
    send(1);
    chk("lat_valid", int'(out_valid), 1);
    chk("lat_acc", int'(out_acc), 2);
    consume();
    n_samples = 6'd0;
    send(7);
    chk("n0_valid", int'(out_valid), 1);
    chk("n0_acc", int'(out_acc), 7);
    chk("n0_count", int'(out_count), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hold_rst_valid", int'(out_valid), 0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst       = ($urandom % 300) == 0;
      clear     = ($urandom % 50) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_sum    = SUM_W'($urandom_range(0, 127));
      n_samples = (($urandom % 8) == 0) ? COUNT_W'($urandom_range(0, 63))
                                        : COUNT_W'($urandom_range(0, 6));
      out_ready = ($urandom % 3) == 0;
      tick();
    end
    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
